// File: rtl/tb_data_ram_wait.sv
// Data-memory model backing the CPU data port in simulation benches.
// Word-organised 32-bit storage with a programmable number of wait states
// (waitrequest handshake), byte-lane writes, address range and alignment
// checking, a sticky protocol-error flag and an independent registered
// debug read port for end-of-test result inspection.
module tb_data_ram_wait #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  input  logic        dbg_read,
  input  logic [31:0] dbg_address,
  output logic [31:0] dbg_readdata,
  output logic        dbg_valid,
  output logic        protocol_error,
  output logic [31:0] write_count
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_STATES);

  // Word storage; never touched by reset so results survive a bench reset.
  logic [31:0] mem [DEPTH_WORDS];

  // Preload: all zero.
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'h0;
  end

  // A 33-bit difference catches addresses below the base without a
  // comparison against a possibly-zero constant.
  function automatic logic in_range_f(input logic [31:0] addr);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, ADDR_BASE};
    return !diff[32] && ((diff[31:0] >> 2) < DEPTH_U);
  endfunction

  function automatic logic aligned_f(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  // Only meaningful when in_range_f() holds; truncation is then lossless.
  function automatic logic [IDX_W-1:0] index_f(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  // Merge byte lanes of new data over an existing word.
  function automatic logic [31:0] merge_f(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // CPU port decode
  logic             req;
  logic             cpu_in_range;
  logic             cpu_aligned;
  logic [IDX_W-1:0] cpu_index;
  logic             rw_conflict;
  logic             done;
  logic             commit;
  logic             bad_done;

  // Wait-state handshake
  logic [3:0]  wcnt;
  logic        first_wait;
  logic        hold_err;

  // Request image captured on the first waiting edge
  logic [31:0] lat_address;
  logic        lat_read;
  logic        lat_write;
  logic [3:0]  lat_byteenable;
  logic [31:0] lat_writedata;

  // Debug port decode
  logic             dbg_ok;
  logic [IDX_W-1:0] dbg_index;

  assign req          = data_read | data_write;
  assign cpu_in_range = in_range_f(data_address);
  assign cpu_aligned  = aligned_f(data_address);
  assign cpu_index    = index_f(data_address);
  assign rw_conflict  = data_read & data_write;

  // With WAIT_STATES = 0 the counter never leaves 0, so this is constant 0.
  assign data_waitrequest = req && (wcnt != WAIT_LIM);

  assign done       = req && !data_waitrequest;
  assign first_wait = (wcnt == 4'd0) && data_waitrequest;
  assign commit     = done && data_write && !data_read && cpu_in_range && cpu_aligned && !reset;
  assign bad_done   = done && (!cpu_in_range || !cpu_aligned);

  // Once waiting has started, the held request must match the captured one.
  assign hold_err = (wcnt != 4'd0) &&
                    ({data_address, data_read, data_write, data_byteenable, data_writedata} !=
                     {lat_address, lat_read, lat_write, lat_byteenable, lat_writedata});

  assign dbg_ok    = in_range_f(dbg_address) && aligned_f(dbg_address);
  assign dbg_index = index_f(dbg_address);

  // Combinational read data, only for a clean completing read.
  always_comb begin
    data_readdata = 32'h0;
    if (data_read && !data_write && !data_waitrequest && cpu_in_range && cpu_aligned)
      data_readdata = mem[cpu_index];
  end

  // Wait counter: counts waiting edges, restarts on completion or idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= 4'd0;
    end else if (!req) begin
      wcnt <= 4'd0;
    end else if (data_waitrequest) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

  // Capture the request image on the first waiting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_address    <= 32'h0;
      lat_read       <= 1'b0;
      lat_write      <= 1'b0;
      lat_byteenable <= 4'h0;
      lat_writedata  <= 32'h0;
    end else if (first_wait) begin
      lat_address    <= data_address;
      lat_read       <= data_read;
      lat_write      <= data_write;
      lat_byteenable <= data_byteenable;
      lat_writedata  <= data_writedata;
    end
  end

  // Sticky protocol error: unstable held request, read+write, bad address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (hold_err || rw_conflict || bad_done) begin
      protocol_error <= 1'b1;
    end
  end

  // Count committed CPU writes, including all-lanes-disabled writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count <= 32'h0;
    end else if (commit) begin
      write_count <= write_count + 32'd1;
    end
  end

  // Byte-lane memory write on the completion edge; reset drops it.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cpu_index] <= merge_f(mem[cpu_index], data_writedata, data_byteenable);
    end
  end

  // Registered debug read; sees the pre-write word on a same-edge CPU write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_readdata <= 32'h0;
      dbg_valid    <= 1'b0;
    end else if (dbg_read) begin
      dbg_readdata <= dbg_ok ? mem[dbg_index] : 32'h0;
      dbg_valid    <= 1'b1;
    end else begin
      dbg_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tb_data_ram_wait.sv
// Bench for tb_data_ram_wait: three instances with 0, 2 and 3 wait states.
// Expected CPU and debug read data go into scoreboard queues as requests
// are issued and are compared when the DUT presents the data.
module tb_tb_data_ram_wait;

  logic        clk;
  logic        rst      [3];
  logic [31:0] addr     [3];
  logic        rd       [3];
  logic        wr       [3];
  logic [3:0]  be       [3];
  logic [31:0] wd       [3];
  logic [31:0] rdata    [3];
  logic        wreq     [3];
  logic        dbg_rd   [3];
  logic [31:0] dbg_addr [3];
  logic [31:0] drdata   [3];
  logic        dvalid   [3];
  logic        perr     [3];
  logic [31:0] wcount   [3];

  int n_checks;
  int n_pass;
  int n_wait;
  logic [31:0] cpu_q [$];
  logic [31:0] dbg_q [$];

  tb_data_ram_wait #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst[0]), .data_address(addr[0]), .data_read(rd[0]),
    .data_write(wr[0]), .data_byteenable(be[0]), .data_writedata(wd[0]),
    .data_readdata(rdata[0]), .data_waitrequest(wreq[0]), .dbg_read(dbg_rd[0]),
    .dbg_address(dbg_addr[0]), .dbg_readdata(drdata[0]), .dbg_valid(dvalid[0]),
    .protocol_error(perr[0]), .write_count(wcount[0]));

  tb_data_ram_wait #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(rst[1]), .data_address(addr[1]), .data_read(rd[1]),
    .data_write(wr[1]), .data_byteenable(be[1]), .data_writedata(wd[1]),
    .data_readdata(rdata[1]), .data_waitrequest(wreq[1]), .dbg_read(dbg_rd[1]),
    .dbg_address(dbg_addr[1]), .dbg_readdata(drdata[1]), .dbg_valid(dvalid[1]),
    .protocol_error(perr[1]), .write_count(wcount[1]));

  tb_data_ram_wait #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst[2]), .data_address(addr[2]), .data_read(rd[2]),
    .data_write(wr[2]), .data_byteenable(be[2]), .data_writedata(wd[2]),
    .data_readdata(rdata[2]), .data_waitrequest(wreq[2]), .dbg_read(dbg_rd[2]),
    .dbg_address(dbg_addr[2]), .dbg_readdata(drdata[2]), .dbg_valid(dvalid[2]),
    .protocol_error(perr[2]), .write_count(wcount[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one CPU access, hold it through the wait states, check the wait count.
  task automatic cpu_access(input int k, input logic r, input logic w,
                            input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d, input logic [31:0] exp_rd,
                            input int exp_waits, input string tag);
    int waits;
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wd[k] = d;
    if (r && !w) cpu_q.push_back(exp_rd);
    waits = 0;
    @(negedge clk);
    while (wreq[k] && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check_val({tag, "_waits"}, waits, exp_waits);
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic dbg_read(input int k, input logic [31:0] a, input logic [31:0] exp);
    dbg_rd[k] = 1'b1; dbg_addr[k] = a;
    dbg_q.push_back(exp);
    @(posedge clk); #1;
    dbg_rd[k] = 1'b0;
  endtask

  // Scoreboard side: compare whenever a DUT presents read data.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dvalid[k]) begin
        if (dbg_q.size() == 0) check_val($sformatf("dbg%0d_spurious_valid", k), 32'(dvalid[k]), 32'h0);
        else check_val($sformatf("dbg%0d_data", k), drdata[k], dbg_q.pop_front());
      end
      if (rd[k] && !wr[k] && !wreq[k]) begin
        if (cpu_q.size() == 0) check_val($sformatf("cpu%0d_unexpected_read", k), rdata[k], 32'hFFFF_FFFF);
        else check_val($sformatf("cpu%0d_rdata", k), rdata[k], cpu_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_pass = 0; n_wait = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; addr[k] = 32'h0; rd[k] = 1'b0; wr[k] = 1'b0;
      be[k] = 4'h0; wd[k] = 32'h0; dbg_rd[k] = 1'b0; dbg_addr[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst%0d_wcount", k), wcount[k], 32'h0);
      check_val($sformatf("rst%0d_drdata", k), drdata[k], 32'h0);
      check_val($sformatf("rst%0d_dvalid", k), 32'(dvalid[k]), 32'h0);
      check_val($sformatf("rst%0d_perr", k), 32'(perr[k]), 32'h0);
      check_val($sformatf("rst%0d_wreq", k), 32'(wreq[k]), 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Zero wait states: same-cycle read data
    cpu_access(0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h1234_5678, 32'h0, 0, "ws0_wr0");
    cpu_access(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 32'h1234_5678, 0, "ws0_rd0");

    // Same-edge CPU write and debug read return the old word
    cpu_access(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hA5A5_0001, 32'h0, 0, "ws0_wr16");
    wr[0] = 1'b1; addr[0] = 32'h10; be[0] = 4'hF; wd[0] = 32'h5A5A_0002;
    dbg_rd[0] = 1'b1; dbg_addr[0] = 32'h10; dbg_q.push_back(32'hA5A5_0001);
    @(posedge clk); #1;
    wr[0] = 1'b0; dbg_rd[0] = 1'b0;
    dbg_read(0, 32'h10, 32'h5A5A_0002);
    check_val("ws0_wcount3", wcount[0], 32'd3);
    check_val("ws0_perr_clean", 32'(perr[0]), 32'h0);

    // Out of range write and misaligned read (index would alias word 0)
    cpu_access(0, 1'b0, 1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF, 32'h0, 0, "ws0_oor_wr");
    check_val("ws0_oor_wcount", wcount[0], 32'd3);
    check_val("ws0_oor_perr", 32'(perr[0]), 32'h1);
    dbg_read(0, 32'h0, 32'h1234_5678);
    cpu_access(0, 1'b1, 1'b0, 32'h2, 4'hF, 32'h0, 32'h0, 0, "ws0_misal_rd");
    dbg_read(0, 32'h100, 32'h0);

    // Three wait states: write commits on the fourth edge
    cpu_access(2, 1'b0, 1'b1, 32'h4, 4'hF, 32'hDEAD_BEEF, 32'h0, 3, "ws3_wr4");
    check_val("ws3_wcount1", wcount[2], 32'd1);
    dbg_read(2, 32'h4, 32'hDEAD_BEEF);
    cpu_access(2, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 32'hDEAD_BEEF, 3, "ws3_rd4");

    // Byte enables
    cpu_access(2, 1'b0, 1'b1, 32'h8, 4'hF, 32'h1122_3344, 32'h0, 3, "ws3_wr8");
    cpu_access(2, 1'b0, 1'b1, 32'h8, 4'b0101, 32'hAABB_CCDD, 32'h0, 3, "ws3_wr8_be");
    dbg_read(2, 32'h8, 32'h11BB_33DD);
    cpu_access(2, 1'b0, 1'b1, 32'h8, 4'b0000, 32'h0000_0000, 32'h0, 3, "ws3_wr8_be0");
    dbg_read(2, 32'h8, 32'h11BB_33DD);
    check_val("ws3_wcount4", wcount[2], 32'd4);
    check_val("ws3_perr_clean", 32'(perr[2]), 32'h0);

    // Two wait states: address changes while waiting
    cpu_access(1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h1111_0000, 32'h0, 2, "ws2_wr0");
    check_val("ws2_perr_clean", 32'(perr[1]), 32'h0);
    wr[1] = 1'b1; addr[1] = 32'h0; be[1] = 4'hF; wd[1] = 32'h0000_0055;
    @(posedge clk); #1;
    addr[1] = 32'h4;
    n_wait = 0;
    @(negedge clk);
    while (wreq[1] && n_wait < 40) begin
      n_wait++;
      @(negedge clk);
    end
    check_val("ws2_chg_waits", n_wait, 32'd1);
    @(posedge clk); #1;
    wr[1] = 1'b0;
    check_val("ws2_chg_perr", 32'(perr[1]), 32'h1);
    dbg_read(1, 32'h0, 32'h1111_0000);
    dbg_read(1, 32'h4, 32'h0000_0055);
    repeat (3) @(posedge clk);
    #1;
    check_val("ws2_perr_sticky", 32'(perr[1]), 32'h1);
    rst[1] = 1'b1;
    @(negedge clk);
    check_val("ws2_perr_rst", 32'(perr[1]), 32'h0);
    @(posedge clk); #1;
    rst[1] = 1'b0;

    // Reset in the middle of a held write
    cpu_access(2, 1'b0, 1'b1, 32'hC, 4'hF, 32'hCAFE_F00D, 32'h0, 3, "ws3_pre12");
    wr[2] = 1'b1; addr[2] = 32'hC; be[2] = 4'hF; wd[2] = 32'h0BAD_BEEF;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(negedge clk);
    check_val("ws3_rst_wcount", wcount[2], 32'h0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    dbg_rd[2] = 1'b1; dbg_addr[2] = 32'hC; dbg_q.push_back(32'hCAFE_F00D);
    n_wait = 0;
    @(negedge clk);
    while (wreq[2] && n_wait < 40) begin
      n_wait++;
      @(posedge clk); #1;
      dbg_rd[2] = 1'b0;
      @(negedge clk);
    end
    dbg_rd[2] = 1'b0;
    check_val("ws3_rst_rewaits", n_wait, 32'd3);
    @(posedge clk); #1;
    wr[2] = 1'b0;
    check_val("ws3_rst_wcount1", wcount[2], 32'd1);
    dbg_read(2, 32'hC, 32'h0BAD_BEEF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("dbg_q_drained", dbg_q.size(), 32'd0);
    check_val("cpu_q_drained", cpu_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
